hazard_unit_sb: RTL and testbench
=================================

Name: hazard_unit_sb

Overview:
- Parametrised successor of the pipeline hazard unit for the 5-stage Filter-GPU core (F/D/E/M/W), with scalar and vector register files.
- Generates forwarding selects, stalls and flushes, as the previous unit did.
- Adds three pieces of internal state:
  - a PC-write pending tracker, so only PCSrcD is taken as input;
  - a per-register vector scoreboard for multi-cycle (long-latency) vector ops;
  - an outstanding long-op counter with a configurable cap.

Parameters:
- RW, 4, scalar register address width.
- VW, 4, vector register address width; NVREG = 2**VW scoreboard entries.
- LONG_MAX, 4, maximum in-flight long vector ops; counter width CW = $clog2(LONG_MAX+1).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- RA1D, RA2D  in  RW  scalar source registers in D.
- RA1E, RA2E  in  RW  scalar source registers in E.
- WA3E, WA3M, WA3W  in  RW  scalar destination registers in E/M/W.
- RegWriteM, RegWriteW  in  1  scalar writeback enables.
- MemtoRegE  in  1  load in E.
- VRA1D, VRA2D, VWA3D  in  VW  vector sources and destination in D.
- VRegWriteD, VLongD  in  1  D writes a vector register / D is a long vector op.
- VRA1E, VRA2E, VWA3E  in  VW  vector sources and destination in E.
- VLongIssueE  in  1  long vector op leaving E this cycle.
- VWA3M, VWA3W  in  VW  vector destinations in M/W.
- VRegWriteM, VRegWriteW  in  1  short vector writeback enables.
- VLongDoneW  in  1  long op writing back VWA3W this cycle.
- PCSrcD  in  1  D writes the PC.
- BranchTakenE  in  1  early branch resolved taken in E.
- ForwardAE, ForwardBE  out  2  scalar forwarding selects: 10=ALUOutM, 01=ResultW, 00=regfile.
- ForwardVAE, ForwardVBE  out  2  vector forwarding selects, same encoding.
- StallF, StallD, FlushD, FlushE  out  1  pipeline control.
- VBusy  out  NVREG  scoreboard contents, for debug.

Behaviour:
- Reset: while reset=0, asynchronously clear the PC-pend register, the scoreboard, the counter and VBusy. Outputs stay combinational from inputs with zero state.
- Scalar forwarding (per source X in A/B):
  - M match with RegWriteM → 10;
  - else W match with RegWriteW → 01;
  - else 00. M has priority.
- Vector forwarding: same rule using VRegWriteM/VRegWriteW.
  - Long ops never forward; they are covered by the scoreboard.
- LdStall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- SbStall = VBusy[VRA1D] | VBusy[VRA2D] | (VRegWriteD & VBusy[VWA3D]). This covers RAW and WAW.
- CapStall = VLongD & (cnt == LONG_MAX).
- PC tracker: state pendE, pendM, pendW. Each clk:
  - pendE <= PCSrcD & ~FlushE & ~StallD;
  - pendM <= pendE;
  - pendW <= pendM.
- PCWrPendingF = PCSrcD | pendE | pendM.
- Stall/flush outputs:
  - Stall = LdStall | SbStall | CapStall;
  - StallF = Stall | PCWrPendingF;
  - StallD = Stall;
  - FlushE = Stall | BranchTakenE;
  - FlushD = PCWrPendingF | pendW | BranchTakenE.
- Scoreboard, each clk:
  - VLongIssueE sets bit VWA3E;
  - VLongDoneW clears bit VWA3W;
  - same index set and clear in the same cycle → set wins.
- Counter, each clk: cnt += VLongIssueE − VLongDoneW.
  - Both in the same cycle → unchanged.
  - Saturates at 0 and LONG_MAX, never wraps.
  - A done at cnt=0 is ignored, and the VBusy bit stays clear.
- Latency: a set/clear is visible on VBusy and SbStall the cycle after the edge. A D-stage reader of a register cleared this cycle therefore stalls one more cycle; this is required and is not bypassed.
- Reset asserted mid-operation aborts all tracking; the bench must flush the pipeline alongside.

Optional Feature:
- HAZ_VEC_FWD_EN defined: short vector ops forward as described above.
- Undefined:
  - ForwardVAE and ForwardVBE tie to 00.
  - SbStall additionally ORs a D-source match against VWA3E, VWA3M or VWA3W while the corresponding vector write is pending (VRegWriteE is not needed; match on E uses VLongIssueE|VRegWriteM-stage pipeline flags supplied by the same ports).
  - The result is a pure stall-based vector interlock.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum (FWD_RF=00, FWD_W=01, FWD_M=10);
  - default widths RW_DEF=4, VW_DEF=4, LONG_MAX_DEF=4.
- One natural sub-module: vec_scoreboard, holding the busy bits, the counter and the busy/cap outputs. It is instantiated once.
- Forwarding comparators stay inline.

Test Plan:
- Forwarding priority: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. Then drop RegWriteM → ForwardAE=01.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 → StallF=StallD=FlushE=1 for one cycle. With RA2D=6 → all 0.
- Branch tracker: single PCSrcD pulse, no stalls → FlushD=1 for 4 consecutive cycles. StallF=1 for 3 cycles, then 0.
- Scoreboard RAW: VLongIssueE with VWA3E=7, then VRA1D=7 → StallD=1 every cycle until VLongDoneW with VWA3W=7. Stall released the cycle after done. VBusy[7] goes 1→0.
- Cap and simultaneous events: issue 4 long ops → cnt=4, and VLongD=1 stalls. Then issue+done in the same cycle on the same register → bit stays 1 and cnt stays 4.
- Reset mid-op: VBusy=0x0081, cnt=2, pendM=1; assert reset=0 → VBusy=0, cnt=0 and FlushD driven only by inputs, immediately and asynchronously.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, default widths and forwarding-select helper for the hazard unit
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam int RW_DEF       = 4;
   localparam int VW_DEF       = 4;
   localparam int LONG_MAX_DEF = 4;

   // Memory-stage producer is younger than writeback, so it takes priority.
   function automatic fwd_sel_t fwd_pick(input logic m_hit, input logic w_hit);
      if (m_hit) begin
         return FWD_M;
      end
      if (w_hit) begin
         return FWD_W;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/vec_scoreboard.sv
// rtl/vec_scoreboard.sv - per-register busy bits and in-flight counter for long vector ops
module vec_scoreboard
   import hazard_pkg::*;
#(
   parameter int VW       = VW_DEF,
   parameter int LONG_MAX = LONG_MAX_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_i,
   input  logic [VW-1:0]        issue_idx_i,
   input  logic                 done_i,
   input  logic [VW-1:0]        done_idx_i,
   input  logic [VW-1:0]        rd1_idx_i,
   input  logic [VW-1:0]        rd2_idx_i,
   input  logic [VW-1:0]        wr_idx_i,
   input  logic                 wr_en_i,
   input  logic                 long_req_i,
   output logic [(1<<VW)-1:0]   busy_o,
   output logic                 busy_stall_o,
   output logic                 cap_stall_o
);

   localparam int NVREG = 1 << VW;
   localparam int CW    = $clog2(LONG_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LONG_MAX);

   logic [NVREG-1:0] busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_eff;

   // A completion with nothing in flight is spurious and must not touch any state.
   assign done_eff = done_i && (cnt_q != '0);

   // Next-state: clear first so a same-index issue overrides; counter saturates both ways.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (done_eff) begin
         busy_d[done_idx_i] = 1'b0;
      end
      if (issue_i) begin
         busy_d[issue_idx_i] = 1'b1;
      end
      if (issue_i && !done_eff) begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (!issue_i && done_eff) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Busy bits and counter, cleared immediately on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o       = busy_q;
   assign busy_stall_o = busy_q[rd1_idx_i] | busy_q[rd2_idx_i] | (wr_en_i & busy_q[wr_idx_i]);
   assign cap_stall_o  = long_req_i & (cnt_q == CNT_MAX);

endmodule

// File: rtl/hazard_unit_sb.sv
// rtl/hazard_unit_sb.sv - pipeline hazard unit with PC tracker and vector scoreboard; HAZ_VEC_FWD_EN enables vector forwarding
module hazard_unit_sb
   import hazard_pkg::*;
#(
   parameter int RW       = RW_DEF,
   parameter int VW       = VW_DEF,
   parameter int LONG_MAX = LONG_MAX_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [RW-1:0]       RA1D,
   input  logic [RW-1:0]       RA2D,
   input  logic [RW-1:0]       RA1E,
   input  logic [RW-1:0]       RA2E,
   input  logic [RW-1:0]       WA3E,
   input  logic [RW-1:0]       WA3M,
   input  logic [RW-1:0]       WA3W,
   input  logic                RegWriteM,
   input  logic                RegWriteW,
   input  logic                MemtoRegE,
   input  logic [VW-1:0]       VRA1D,
   input  logic [VW-1:0]       VRA2D,
   input  logic [VW-1:0]       VWA3D,
   input  logic                VRegWriteD,
   input  logic                VLongD,
   input  logic [VW-1:0]       VRA1E,
   input  logic [VW-1:0]       VRA2E,
   input  logic [VW-1:0]       VWA3E,
   input  logic                VLongIssueE,
   input  logic [VW-1:0]       VWA3M,
   input  logic [VW-1:0]       VWA3W,
   input  logic                VRegWriteM,
   input  logic                VRegWriteW,
   input  logic                VLongDoneW,
   input  logic                PCSrcD,
   input  logic                BranchTakenE,
   output logic [1:0]          ForwardAE,
   output logic [1:0]          ForwardBE,
   output logic [1:0]          ForwardVAE,
   output logic [1:0]          ForwardVBE,
   output logic                StallF,
   output logic                StallD,
   output logic                FlushD,
   output logic                FlushE,
   output logic [(1<<VW)-1:0]  VBusy
);

   logic ld_stall, sb_busy_stall, cap_stall, vil_stall, stall;
   logic pc_wr_pending_f;
   logic pend_e_q, pend_m_q, pend_w_q, pend_e_d;

   assign ForwardAE = fwd_pick(RegWriteM && (RA1E == WA3M), RegWriteW && (RA1E == WA3W));
   assign ForwardBE = fwd_pick(RegWriteM && (RA2E == WA3M), RegWriteW && (RA2E == WA3W));

`ifdef HAZ_VEC_FWD_EN
   assign ForwardVAE = fwd_pick(VRegWriteM && (VRA1E == VWA3M), VRegWriteW && (VRA1E == VWA3W));
   assign ForwardVBE = fwd_pick(VRegWriteM && (VRA2E == VWA3M), VRegWriteW && (VRA2E == VWA3W));
   assign vil_stall  = 1'b0;
`else
   logic unused_vec_e;
   assign unused_vec_e = ^{VRA1E, VRA2E};
   assign ForwardVAE   = FWD_RF;
   assign ForwardVBE   = FWD_RF;
   // Without vector bypass, any D source matching a pending vector write downstream must wait.
   assign vil_stall = (VLongIssueE && ((VRA1D == VWA3E) || (VRA2D == VWA3E)))
                    | (VRegWriteM  && ((VRA1D == VWA3M) || (VRA2D == VWA3M)))
                    | (VRegWriteW  && ((VRA1D == VWA3W) || (VRA2D == VWA3W)));
`endif

   assign ld_stall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));

   vec_scoreboard #(
      .VW       (VW),
      .LONG_MAX (LONG_MAX)
   ) u_vec_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .issue_i      (VLongIssueE),
      .issue_idx_i  (VWA3E),
      .done_i       (VLongDoneW),
      .done_idx_i   (VWA3W),
      .rd1_idx_i    (VRA1D),
      .rd2_idx_i    (VRA2D),
      .wr_idx_i     (VWA3D),
      .wr_en_i      (VRegWriteD),
      .long_req_i   (VLongD),
      .busy_o       (VBusy),
      .busy_stall_o (sb_busy_stall),
      .cap_stall_o  (cap_stall)
   );

   assign stall           = ld_stall | sb_busy_stall | cap_stall | vil_stall;
   assign pc_wr_pending_f = PCSrcD | pend_e_q | pend_m_q;

   assign StallF = stall | pc_wr_pending_f;
   assign StallD = stall;
   assign FlushE = stall | BranchTakenE;
   assign FlushD = pc_wr_pending_f | pend_w_q | BranchTakenE;

   // A PC write only enters the tracker if the D instruction actually advances into E.
   assign pend_e_d = PCSrcD & ~FlushE & ~StallD;

   // PC-write tracker follows the writing instruction through E, M and W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_e_q <= 1'b0;
         pend_m_q <= 1'b0;
         pend_w_q <= 1'b0;
      end else begin
         pend_e_q <= pend_e_d;
         pend_m_q <= pend_e_q;
         pend_w_q <= pend_m_q;
      end
   end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb/tb_hazard_unit_sb.sv - randomized and directed self-checking bench for hazard_unit_sb
module tb_hazard_unit_sb;

   localparam int RW   = 4;
   localparam int VW   = 4;
   localparam int LMAX = 4;
   localparam int NV   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [RW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic          RegWriteM, RegWriteW, MemtoRegE;
   logic [VW-1:0] VRA1D, VRA2D, VWA3D, VRA1E, VRA2E, VWA3E, VWA3M, VWA3W;
   logic          VRegWriteD, VLongD, VLongIssueE, VRegWriteM, VRegWriteW, VLongDoneW;
   logic          PCSrcD, BranchTakenE;
   logic [1:0]    ForwardAE, ForwardBE, ForwardVAE, ForwardVBE;
   logic          StallF, StallD, FlushD, FlushE;
   logic [NV-1:0] VBusy;

   hazard_unit_sb dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
      .VRA1D(VRA1D), .VRA2D(VRA2D), .VWA3D(VWA3D), .VRegWriteD(VRegWriteD), .VLongD(VLongD),
      .VRA1E(VRA1E), .VRA2E(VRA2E), .VWA3E(VWA3E), .VLongIssueE(VLongIssueE),
      .VWA3M(VWA3M), .VWA3W(VWA3W), .VRegWriteM(VRegWriteM), .VRegWriteW(VRegWriteW),
      .VLongDoneW(VLongDoneW), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardVAE(ForwardVAE), .ForwardVBE(ForwardVBE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .VBusy(VBusy)
   );

   int n_checks = 0;
   int n_errors = 0;

   bit [NV-1:0] m_busy;
   int          m_cnt;
   int          m_ages[$];

   logic [1:0] e_fa, e_fb, e_fva, e_fvb;
   logic       e_stf, e_std, e_fld, e_fle;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input int src, input bit wm, input int am, input bit ww, input int aw);
      if (wm && src == am) return 2'd2;
      if (ww && src == aw) return 2'd1;
      return 2'd0;
   endfunction

   task automatic clear_inputs();
      {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
      {RegWriteM, RegWriteW, MemtoRegE} = '0;
      {VRA1D, VRA2D, VWA3D, VRA1E, VRA2E, VWA3E, VWA3M, VWA3W} = '0;
      {VRegWriteD, VLongD, VLongIssueE, VRegWriteM, VRegWriteW, VLongDoneW} = '0;
      {PCSrcD, BranchTakenE} = '0;
   endtask

   task automatic compute_expect();
      bit ld, sb, cap, stall, pend_em, pend_w, pcw;
      e_fa = ref_fwd(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      e_fb = ref_fwd(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
`ifdef HAZ_VEC_FWD_EN
      e_fva = ref_fwd(VRA1E, VRegWriteM, VWA3M, VRegWriteW, VWA3W);
      e_fvb = ref_fwd(VRA2E, VRegWriteM, VWA3M, VRegWriteW, VWA3W);
`else
      e_fva = 2'd0;
      e_fvb = 2'd0;
`endif
      ld = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
      sb = m_busy[VRA1D] || m_busy[VRA2D] || (VRegWriteD && m_busy[VWA3D]);
`ifndef HAZ_VEC_FWD_EN
      for (int s = 0; s < 2; s++) begin
         int src;
         src = (s == 0) ? int'(VRA1D) : int'(VRA2D);
         if (VLongIssueE && src == VWA3E) sb = 1;
         if (VRegWriteM && src == VWA3M) sb = 1;
         if (VRegWriteW && src == VWA3W) sb = 1;
      end
`endif
      cap   = VLongD && (m_cnt == LMAX);
      stall = ld || sb || cap;
      pend_em = 0;
      pend_w  = 0;
      foreach (m_ages[i]) begin
         if (m_ages[i] <= 2) pend_em = 1;
         if (m_ages[i] == 3) pend_w = 1;
      end
      pcw   = PCSrcD || pend_em;
      e_stf = stall || pcw;
      e_std = stall;
      e_fle = stall || BranchTakenE;
      e_fld = pcw || pend_w || BranchTakenE;
   endtask

   task automatic advance();
      int  nq[$];
      bit  acc, done_ok;
      acc = PCSrcD && !e_fle && !e_std;
      foreach (m_ages[i]) if (m_ages[i] < 3) nq.push_back(m_ages[i] + 1);
      if (acc) nq.push_back(1);
      m_ages = nq;
      done_ok = VLongDoneW && (m_cnt > 0);
      if (done_ok) m_busy[VWA3W] = 1'b0;
      if (VLongIssueE) m_busy[VWA3E] = 1'b1;
      if (VLongIssueE && !done_ok) m_cnt = (m_cnt < LMAX) ? m_cnt + 1 : LMAX;
      else if (!VLongIssueE && done_ok) m_cnt = m_cnt - 1;
   endtask

   task automatic check_all(input string tag);
      compute_expect();
      check_eq({tag, ".fwd"}, {ForwardAE, ForwardBE, ForwardVAE, ForwardVBE}, {e_fa, e_fb, e_fva, e_fvb});
      check_eq({tag, ".ctl"}, {StallF, StallD, FlushD, FlushE}, {e_stf, e_std, e_fld, e_fle});
      check_eq({tag, ".vbusy"}, VBusy, m_busy);
   endtask

   task automatic settle(input string tag);
      #1;
      check_all(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      advance();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      reset  = 1'b0;
      m_busy = '0;
      m_cnt  = 0;
      #3;
      check_all("reset");
      check_eq("reset_vbusy", VBusy, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // forwarding priority
      RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
      settle("fwd_m");
      check_eq("fwd_prio_m", ForwardAE, 2'b10);
      tick();
      RegWriteM = 0;
      settle("fwd_w");
      check_eq("fwd_prio_w", ForwardAE, 2'b01);
      tick();
      clear_inputs();

      // load-use
      MemtoRegE = 1; WA3E = 5; RA2D = 5;
      settle("ld_hit");
      check_eq("ld_stall", {StallF, StallD, FlushE}, 3'b111);
      tick();
      RA2D = 6;
      settle("ld_miss");
      check_eq("ld_nostall", {StallF, StallD, FlushE}, 3'b000);
      tick();
      clear_inputs();

      // branch tracker
      PCSrcD = 1;
      settle("br0");
      check_eq("br_flushd0", FlushD, 1'b1);
      check_eq("br_stallf0", StallF, 1'b1);
      tick();
      PCSrcD = 0;
      for (int i = 1; i <= 4; i++) begin
         settle("br");
         check_eq("br_flushd", FlushD, (i < 4) ? 1'b1 : 1'b0);
         check_eq("br_stallf", StallF, (i < 3) ? 1'b1 : 1'b0);
         tick();
      end

      // scoreboard RAW
      VLongIssueE = 1; VWA3E = 7;
      settle("raw_issue");
      tick();
      clear_inputs();
      VRA1D = 7;
      for (int i = 0; i < 3; i++) begin
         settle("raw_wait");
         check_eq("raw_stall", StallD, 1'b1);
         check_eq("raw_busy7", VBusy[7], 1'b1);
         tick();
      end
      VLongDoneW = 1; VWA3W = 7;
      settle("raw_done");
      check_eq("raw_stall_done_cyc", StallD, 1'b1);
      tick();
      VLongDoneW = 0;
      settle("raw_rel");
      check_eq("raw_release", StallD, 1'b0);
      check_eq("raw_busy7_clr", VBusy[7], 1'b0);
      tick();
      clear_inputs();

      // done with nothing in flight is ignored
      VLongDoneW = 1; VWA3W = 2;
      settle("idle_done");
      tick();
      clear_inputs();
      settle("idle_after");
      check_eq("idle_vbusy", VBusy, 16'h0000);
      tick();

      // cap and simultaneous issue/done
      for (int r = 1; r <= 4; r++) begin
         VLongIssueE = 1; VWA3E = r[VW-1:0];
         settle("cap_fill");
         tick();
      end
      clear_inputs();
      VLongD = 1;
      settle("cap_full");
      check_eq("cap_stall", StallD, 1'b1);
      tick();
      VLongIssueE = 1; VWA3E = 4; VLongDoneW = 1; VWA3W = 4;
      settle("cap_both");
      tick();
      clear_inputs();
      VLongD = 1;
      settle("cap_after_both");
      check_eq("both_bit4", VBusy[4], 1'b1);
      check_eq("both_cap", StallD, 1'b1);
      tick();
      clear_inputs();
      for (int r = 1; r <= 4; r++) begin
         VLongDoneW = 1; VWA3W = r[VW-1:0];
         settle("drain");
         tick();
      end
      clear_inputs();
      VLongD = 1;
      settle("cap_free");
      check_eq("cap_free_stall", StallD, 1'b0);
      tick();
      clear_inputs();

      // reset in the middle of activity
      VRA1D = 9; VRA2D = 9; PCSrcD = 1; VLongIssueE = 1; VWA3E = 0;
      settle("rst_a");
      tick();
      PCSrcD = 0; VWA3E = 7;
      settle("rst_b");
      tick();
      clear_inputs();
      VRA1D = 9; VRA2D = 9;
      settle("rst_pre");
      check_eq("rst_pre_vbusy", VBusy, 16'h0081);
      check_eq("rst_pre_flushd", FlushD, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      m_busy = '0;
      m_cnt  = 0;
      m_ages.delete();
      check_eq("rst_vbusy", VBusy, 16'h0000);
      check_eq("rst_flushd", FlushD, 1'b0);
      check_eq("rst_stallf", StallF, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      settle("rst_rel");
      tick();
      VLongD = 1;
      settle("rst_cnt");
      check_eq("rst_cnt_zero", StallD, 1'b0);
      tick();
      clear_inputs();

      // randomized traffic
      for (int c = 0; c < 500; c++) begin
         RA1D = $urandom_range(0, 3); RA2D = $urandom_range(0, 3);
         RA1E = $urandom_range(0, 3); RA2E = $urandom_range(0, 3);
         WA3E = $urandom_range(0, 3); WA3M = $urandom_range(0, 3); WA3W = $urandom_range(0, 3);
         RegWriteM = $urandom_range(0, 1); RegWriteW = $urandom_range(0, 1);
         MemtoRegE = ($urandom_range(0, 3) == 0);
         VRA1D = $urandom_range(0, 7); VRA2D = $urandom_range(0, 7); VWA3D = $urandom_range(0, 7);
         VRA1E = $urandom_range(0, 7); VRA2E = $urandom_range(0, 7);
         VWA3M = $urandom_range(0, 7); VWA3W = $urandom_range(0, 7);
         VRegWriteD = $urandom_range(0, 1); VLongD = $urandom_range(0, 1);
         VRegWriteM = ($urandom_range(0, 2) == 0); VRegWriteW = ($urandom_range(0, 2) == 0);
         VLongIssueE = (m_cnt < LMAX) && ($urandom_range(0, 2) == 0);
         VWA3E = $urandom_range(0, 7);
         VLongDoneW = 0;
         if (m_busy != '0 && $urandom_range(0, 2) == 0) begin
            int k;
            do k = $urandom_range(0, NV - 1); while (!m_busy[k]);
            VLongDoneW = 1;
            VWA3W = k[VW-1:0];
         end
         PCSrcD = ($urandom_range(0, 7) == 0);
         BranchTakenE = ($urandom_range(0, 9) == 0);
         settle("rand");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
